// File: rtl/io_intc.sv
// io_intc: NUM_CH edge-detected, maskable request channels with fixed priority (channel 0 highest),
// a vectored request/ack/done handshake to ControlBlock. Define IO_INTC_SYNC_EN to add a 2-flop irq_in synchronizer.
module io_intc #(
    parameter int                NUM_CH     = 4,
    parameter int                ADDR_W     = 13,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 13'h1000,
    parameter int                VEC_STRIDE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] irq_in,
    input  logic              en_wr,
    input  logic [NUM_CH-1:0] en_data,
    input  logic              gie_set,
    input  logic              gie_clr,
    input  logic [NUM_CH-1:0] pend_clr,
    input  logic              int_ack,
    input  logic              int_done,
    output logic              int_req,
    output logic [3:0]        int_id,
    output logic [ADDR_W-1:0] int_vec,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] en_mask,
    output logic              glob_ie,
    output logic              in_service
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t              state_reg;
    logic [NUM_CH-1:0]   irq_det;
    logic [NUM_CH-1:0]   irq_prev_reg;
    logic [NUM_CH-1:0]   irq_edge;
    logic [NUM_CH-1:0]   pending_reg;
    logic [NUM_CH-1:0]   pending_next;
    logic [NUM_CH-1:0]   en_mask_reg;
    logic [NUM_CH-1:0]   lat_sel;
    logic [NUM_CH-1:0]   elig;
    logic                glob_ie_reg;
    logic                int_req_reg;
    logic                in_service_reg;
    logic [3:0]          int_id_reg;
    logic [ADDR_W-1:0]   int_vec_reg;
    logic [3:0]          win_id;
    logic [ADDR_W-1:0]   win_vec;
    logic                ack_take;
    logic                lat_live;

`ifdef IO_INTC_SYNC_EN
    logic [NUM_CH-1:0] sync1_reg;
    logic [NUM_CH-1:0] sync2_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= irq_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign irq_det = sync2_reg;
`else
    assign irq_det = irq_in;
`endif

    assign irq_edge = irq_det & ~irq_prev_reg;
    assign ack_take = (state_reg == REQ) && int_ack;
    assign elig     = pending_reg & en_mask_reg;

    // A fresh edge beats any clear landing on the same bit in the same cycle.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign lat_sel[gi]      = (int_id_reg == 4'(gi));
            assign pending_next[gi] = irq_edge[gi] |
                                      (pending_reg[gi] & ~pend_clr[gi] & ~(ack_take & lat_sel[gi]));
        end
    endgenerate

    assign lat_live = |(elig & lat_sel);

    always_comb begin
        win_id = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (elig[i]) win_id = 4'(i);
        end
    end

    assign win_vec = VEC_BASE + ADDR_W'(win_id) * ADDR_W'(VEC_STRIDE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            irq_prev_reg   <= '0;
            pending_reg    <= '0;
            en_mask_reg    <= '0;
            glob_ie_reg    <= 1'b0;
            int_req_reg    <= 1'b0;
            in_service_reg <= 1'b0;
            int_id_reg     <= '0;
            int_vec_reg    <= '0;
        end else begin
            irq_prev_reg <= irq_det;
            pending_reg  <= pending_next;
            if (en_wr) en_mask_reg <= en_data;
            if (gie_clr)      glob_ie_reg <= 1'b0;
            else if (gie_set) glob_ie_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (glob_ie_reg && (|elig)) begin
                        int_id_reg  <= win_id;
                        int_vec_reg <= win_vec;
                        int_req_reg <= 1'b1;
                        state_reg   <= REQ;
                    end
                end
                REQ: begin
                    // Ack outranks a concurrent gie_clr; otherwise losing enable or the bit withdraws.
                    if (int_ack) begin
                        glob_ie_reg    <= 1'b0;
                        int_req_reg    <= 1'b0;
                        in_service_reg <= 1'b1;
                        state_reg      <= SERVICE;
                    end else if (!glob_ie_reg || gie_clr || !lat_live) begin
                        int_req_reg <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end
                SERVICE: begin
                    if (int_done) begin
                        glob_ie_reg    <= ~gie_clr;
                        in_service_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign int_req    = int_req_reg;
    assign int_id     = int_id_reg;
    assign int_vec    = int_vec_reg;
    assign pending    = pending_reg;
    assign en_mask    = en_mask_reg;
    assign glob_ie    = glob_ie_reg;
    assign in_service = in_service_reg;

endmodule

// File: tb/tb_io_intc.sv
// Directed bench for io_intc: default instance plus a VEC_BASE=13'h1FFE instance for vector wrap.
module tb_io_intc;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq_in;
    logic        en_wr;
    logic [3:0]  en_data;
    logic        gie_set;
    logic        gie_clr;
    logic [3:0]  pend_clr;
    logic        int_ack;
    logic        int_done;
    logic        int_req,    w_int_req;
    logic [3:0]  int_id,     w_int_id;
    logic [12:0] int_vec,    w_int_vec;
    logic [3:0]  pending,    w_pending;
    logic [3:0]  en_mask,    w_en_mask;
    logic        glob_ie,    w_glob_ie;
    logic        in_service, w_in_service;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    io_intc dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .en_wr(en_wr), .en_data(en_data),
        .gie_set(gie_set), .gie_clr(gie_clr), .pend_clr(pend_clr),
        .int_ack(int_ack), .int_done(int_done),
        .int_req(int_req), .int_id(int_id), .int_vec(int_vec), .pending(pending),
        .en_mask(en_mask), .glob_ie(glob_ie), .in_service(in_service)
    );

    io_intc #(.VEC_BASE(13'h1FFE)) dut_w (
        .clk(clk), .rst(rst), .irq_in(irq_in), .en_wr(en_wr), .en_data(en_data),
        .gie_set(gie_set), .gie_clr(gie_clr), .pend_clr(pend_clr),
        .int_ack(int_ack), .int_done(int_done),
        .int_req(w_int_req), .int_id(w_int_id), .int_vec(w_int_vec), .pending(w_pending),
        .en_mask(w_en_mask), .glob_ie(w_glob_ie), .in_service(w_in_service)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_in = '0; en_wr = 0; en_data = '0; gie_set = 0; gie_clr = 0;
        pend_clr = '0; int_ack = 0; int_done = 0;
        tick(); tick();
        rst = 1'b0;
        tests_run++; if ({int_req, in_service, glob_ie} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b expected 000", {int_req, in_service, glob_ie}); end
        tests_run++; if ({pending, en_mask, int_id} !== 12'h000) begin tests_failed++; $display("FAIL reset_regs: got %h expected 000", {pending, en_mask, int_id}); end
        tests_run++; if (int_vec !== 13'h0000) begin tests_failed++; $display("FAIL reset_vec: got %h expected 0000", int_vec); end
        $display("[TB] reset: pending=%b en_mask=%b int_vec=%h", pending, en_mask, int_vec);
    endtask

    task automatic test_basic();
        gie_set = 1; en_wr = 1; en_data = 4'b1111;
        tick();
        gie_set = 0; en_wr = 0;
        tests_run++; if ({glob_ie, en_mask} !== 5'b11111) begin tests_failed++; $display("FAIL basic_enable: got %b expected 11111", {glob_ie, en_mask}); end
        irq_in = 4'b0100;
        tick();
        tests_run++; if (pending !== 4'b0100) begin tests_failed++; $display("FAIL basic_pending: got %b expected 0100", pending); end
        tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL basic_req_early: got %b expected 0", int_req); end
        irq_in = 4'b0000;
        tick();
        tests_run++; if ({int_req, int_id} !== 5'b1_0010) begin tests_failed++; $display("FAIL basic_req: got req=%b id=%0d expected req=1 id=2", int_req, int_id); end
        tests_run++; if (int_vec !== 13'h1008) begin tests_failed++; $display("FAIL basic_vec: got %h expected 1008", int_vec); end
        int_ack = 1;
        tick();
        int_ack = 0;
        tests_run++; if ({pending, glob_ie, in_service, int_req} !== 7'b0000_010) begin tests_failed++; $display("FAIL basic_ack: got %b expected 0000010", {pending, glob_ie, in_service, int_req}); end
        int_done = 1;
        tick();
        int_done = 0;
        tests_run++; if ({glob_ie, in_service} !== 2'b10) begin tests_failed++; $display("FAIL basic_done: got %b expected 10", {glob_ie, in_service}); end
        $display("[TB] basic: ch2 vec=1008 served");
    endtask

    task automatic test_priority();
        irq_in = 4'b1010;
        tick();
        irq_in = 4'b0000;
        tests_run++; if (pending !== 4'b1010) begin tests_failed++; $display("FAIL prio_pending: got %b expected 1010", pending); end
        tick();
        tests_run++; if ({int_req, int_id, int_vec} !== {1'b1, 4'd1, 13'h1004}) begin tests_failed++; $display("FAIL prio_first: got req=%b id=%0d vec=%h expected 1 1 1004", int_req, int_id, int_vec); end
        int_ack = 1;
        tick();
        int_ack = 0;
        tests_run++; if ({pending, in_service} !== 5'b1000_1) begin tests_failed++; $display("FAIL prio_ack: got %b expected 10001", {pending, in_service}); end
        int_done = 1;
        tick();
        int_done = 0;
        tick();
        tests_run++; if ({int_req, int_id, int_vec} !== {1'b1, 4'd3, 13'h100C}) begin tests_failed++; $display("FAIL prio_second: got req=%b id=%0d vec=%h expected 1 3 100c", int_req, int_id, int_vec); end
        int_ack = 1;
        tick();
        int_ack = 0; int_done = 1;
        tick();
        int_done = 0;
        tests_run++; if ({pending, in_service, glob_ie} !== 6'b0000_01) begin tests_failed++; $display("FAIL prio_done: got %b expected 000001", {pending, in_service, glob_ie}); end
        $display("[TB] priority: ch1 then ch3");
    endtask

    task automatic test_mask_withdraw();
        en_wr = 1; en_data = 4'b0111;
        tick();
        en_wr = 0; irq_in = 4'b1000;
        tick();
        irq_in = 4'b0000;
        tests_run++; if (pending !== 4'b1000) begin tests_failed++; $display("FAIL mask_pending: got %b expected 1000", pending); end
        tick(); tick();
        tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL mask_blocked: got %b expected 0", int_req); end
        en_wr = 1; en_data = 4'b1111;
        tick();
        en_wr = 0;
        tests_run++; if ({en_mask, int_req} !== 5'b1111_0) begin tests_failed++; $display("FAIL mask_load: got %b expected 11110", {en_mask, int_req}); end
        tick();
        tests_run++; if ({int_req, int_id} !== 5'b1_0011) begin tests_failed++; $display("FAIL mask_unblock: got req=%b id=%0d expected 1 3", int_req, int_id); end
        gie_clr = 1;
        tick();
        gie_clr = 0;
        tests_run++; if ({int_req, glob_ie, pending} !== 6'b00_1000) begin tests_failed++; $display("FAIL withdraw: got %b expected 001000", {int_req, glob_ie, pending}); end
        tick();
        tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL withdraw_idle: got %b expected 0", int_req); end
        gie_set = 1;
        tick();
        gie_set = 0;
        tick();
        tests_run++; if ({int_req, int_id} !== 5'b1_0011) begin tests_failed++; $display("FAIL rerequest: got req=%b id=%0d expected 1 3", int_req, int_id); end
        int_ack = 1; gie_clr = 1;
        tick();
        int_ack = 0; gie_clr = 0;
        tests_run++; if ({in_service, glob_ie, int_req, pending} !== 7'b100_0000) begin tests_failed++; $display("FAIL ack_vs_clr: got %b expected 1000000", {in_service, glob_ie, int_req, pending}); end
        int_done = 1;
        tick();
        int_done = 0;
        gie_set = 1; gie_clr = 1;
        tick();
        gie_set = 0; gie_clr = 0;
        tests_run++; if ({glob_ie, in_service} !== 2'b00) begin tests_failed++; $display("FAIL set_clr: got %b expected 00", {glob_ie, in_service}); end
        $display("[TB] mask/withdraw: ch3 masked, withdrawn, served");
    endtask

    task automatic test_simultaneous();
        int_ack = 1;
        tick();
        int_ack = 0;
        tests_run++; if ({in_service, int_req} !== 2'b00) begin tests_failed++; $display("FAIL stray_ack: got %b expected 00", {in_service, int_req}); end
        gie_set = 1;
        tick();
        gie_set = 0; irq_in = 4'b0100;
        tick();
        irq_in = 4'b0000;
        tick();
        tests_run++; if ({int_req, int_id} !== 5'b1_0010) begin tests_failed++; $display("FAIL sim_req: got req=%b id=%0d expected 1 2", int_req, int_id); end
        irq_in = 4'b0100; int_ack = 1;
        tick();
        irq_in = 4'b0000; int_ack = 0;
        tests_run++; if ({pending, in_service} !== 5'b0100_1) begin tests_failed++; $display("FAIL edge_vs_ack: got %b expected 01001", {pending, in_service}); end
        int_done = 1; gie_clr = 1;
        tick();
        int_done = 0; gie_clr = 0;
        tests_run++; if ({glob_ie, in_service} !== 2'b00) begin tests_failed++; $display("FAIL done_vs_clr: got %b expected 00", {glob_ie, in_service}); end
        pend_clr = 4'b0100;
        tick();
        pend_clr = 4'b0000;
        tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL pend_clr: got %b expected 0000", pending); end
        $display("[TB] simultaneous: edge beats ack clear, clr beats done");
    endtask

    task automatic test_wrap_reset();
        rst = 1;
        tick();
        rst = 0; gie_set = 1; en_wr = 1; en_data = 4'b1111;
        tick();
        gie_set = 0; en_wr = 0; irq_in = 4'b0010;
        tick();
        irq_in = 4'b0000;
        tick();
        tests_run++; if ({w_int_req, w_int_id, w_int_vec} !== {1'b1, 4'd1, 13'h0002}) begin tests_failed++; $display("FAIL wrap_vec: got req=%b id=%0d vec=%h expected 1 1 0002", w_int_req, w_int_id, w_int_vec); end
        int_ack = 1; irq_in = 4'b0001;
        tick();
        int_ack = 0;
        tests_run++; if ({in_service, pending} !== 5'b1_0001) begin tests_failed++; $display("FAIL wrap_service: got %b expected 10001", {in_service, pending}); end
        rst = 1;
        tick();
        rst = 0; irq_in = 4'b0000;
        tests_run++; if ({int_req, in_service, glob_ie, pending, en_mask, int_id} !== 15'h0) begin tests_failed++; $display("FAIL reset_service: got %h expected 0", {int_req, in_service, glob_ie, pending, en_mask, int_id}); end
        tests_run++; if (int_vec !== 13'h0000) begin tests_failed++; $display("FAIL reset_service_vec: got %h expected 0000", int_vec); end
        tick();
        tests_run++; if ({int_req, pending} !== 5'b0) begin tests_failed++; $display("FAIL reset_residue: got %b expected 00000", {int_req, pending}); end
        $display("[TB] wrap/reset: vec=%h, reset mid-service", w_int_vec);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_mask_withdraw();
        test_simultaneous();
        test_wrap_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
